// File: rtl/memory_arbiter_pkg.sv
// Shared types for the data-memory bus arbiter: requester identity and the
// per-stage read tag carried alongside an outstanding read.
package mem_arb_pkg;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_DMA = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } read_tag_t;

  localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/memory_arbiter_read_tag_pipe.sv
// Fixed-depth shift register of read tags; the last stage lines up with the
// cycle in which the memory returns data for the tagged read.
module read_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic      clk,
  input  logic      rst,
  input  read_tag_t tag_i,
  output read_tag_t tag_o
);

  read_tag_t stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/memory_arbiter.sv
// Two-requester arbiter for the data-memory bus: fixed CPU priority with a
// starvation limit for DMA, and read responses routed back by owner tag.
module memory_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_address,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              bus_valid,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_address,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata
);

  localparam logic [STARVE_CNT_W-1:0] STARVE_MAX = STARVE_CNT_W'(STARVE_LIMIT);

  logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  read_tag_t               tag_in, tag_out;

  // Grants are suppressed during reset so nothing reaches the bus or the tag pipe.
  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (!rst) begin
      if (cpu_req && dma_req) begin
        if (starve_cnt_q == STARVE_MAX) dma_gnt = 1'b1;
        else                            cpu_gnt = 1'b1;
      end else begin
        cpu_gnt = cpu_req;
        dma_gnt = dma_req;
      end
    end
  end

  always_comb begin
    starve_cnt_d = '0;
    if (dma_req && !dma_gnt) begin
      starve_cnt_d = (starve_cnt_q == STARVE_MAX) ? starve_cnt_q : starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) starve_cnt_q <= '0;
    else     starve_cnt_q <= starve_cnt_d;
  end

  always_comb begin
    bus_valid   = cpu_gnt | dma_gnt;
    bus_we      = 1'b0;
    bus_address = '0;
    bus_wdata   = '0;
    if (cpu_gnt) begin
      bus_we      = cpu_we;
      bus_address = cpu_address;
      bus_wdata   = cpu_wdata;
    end else if (dma_gnt) begin
      bus_we      = dma_we;
      bus_address = dma_address;
      bus_wdata   = dma_wdata;
    end
  end

  always_comb begin
    tag_in.valid = bus_valid && !bus_we;
    tag_in.owner = dma_gnt ? OWNER_DMA : OWNER_CPU;
  end

  read_tag_pipe #(
    .DEPTH (READ_LATENCY)
  ) u_tag_pipe (
    .clk   (clk),
    .rst   (rst),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  always_comb begin
    cpu_rvalid = !rst && tag_out.valid && (tag_out.owner == OWNER_CPU);
    dma_rvalid = !rst && tag_out.valid && (tag_out.owner == OWNER_DMA);
    cpu_rdata  = cpu_rvalid ? bus_rdata : '0;
    dma_rdata  = dma_rvalid ? bus_rdata : '0;
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios then random traffic, all
// checked every cycle against a queue-based reference of grants and responses.
module tb_memory_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int RL = 2;
  localparam int SL = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_address = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_gnt, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          dma_req = 1'b0, dma_we = 1'b0;
  logic [AW-1:0] dma_address = '0;
  logic [DW-1:0] dma_wdata = '0;
  logic          dma_gnt, dma_rvalid;
  logic [DW-1:0] dma_rdata;
  logic          bus_valid, bus_we;
  logic [AW-1:0] bus_address;
  logic [DW-1:0] bus_wdata;
  logic [DW-1:0] bus_rdata = '0;

  always #5 clk = ~clk;

  memory_arbiter #(
    .DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(RL), .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_address(cpu_address), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_address(dma_address), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .bus_valid(bus_valid), .bus_we(bus_we), .bus_address(bus_address),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: a read granted in cycle c is answered in cycle c+RL, in grant order.
  typedef struct {
    int due;
    bit to_dma;
  } resp_t;

  resp_t resp_q[$];
  int    cyc      = 0;
  int    m_starve = 0;
  bit    last_cgnt, last_dgnt;

  task automatic step(input bit r,
                      input bit creq, input bit cwe, input logic [AW-1:0] ca, input logic [DW-1:0] cw,
                      input bit dreq, input bit dwe, input logic [AW-1:0] da, input logic [DW-1:0] dw);
    bit            eg_c, eg_d, resp_c, resp_d, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, rd;
    @(negedge clk);
    rst = r;
    cpu_req = creq; cpu_we = cwe; cpu_address = ca; cpu_wdata = cw;
    dma_req = dreq; dma_we = dwe; dma_address = da; dma_wdata = dw;
    rd = $urandom;
    bus_rdata = rd;
    #1;
    eg_c = 1'b0;
    eg_d = 1'b0;
    if (!r) begin
      if (creq && dreq) begin
        if (m_starve == SL) eg_d = 1'b1;
        else                eg_c = 1'b1;
      end else begin
        eg_c = creq;
        eg_d = dreq;
      end
    end
    resp_c = 1'b0;
    resp_d = 1'b0;
    if (resp_q.size() > 0 && resp_q[0].due == cyc) begin
      if (!r) begin
        if (resp_q[0].to_dma) resp_d = 1'b1;
        else                  resp_c = 1'b1;
      end
      void'(resp_q.pop_front());
    end
    e_we    = eg_c ? cwe : (eg_d ? dwe : 1'b0);
    e_addr  = eg_c ? ca  : (eg_d ? da  : '0);
    e_wdata = eg_c ? cw  : (eg_d ? dw  : '0);

    check_eq("starve_cnt",  64'(dut.starve_cnt_q), 64'(m_starve));
    check_eq("cpu_gnt",     64'(cpu_gnt),     64'(eg_c));
    check_eq("dma_gnt",     64'(dma_gnt),     64'(eg_d));
    check_eq("bus_valid",   64'(bus_valid),   64'(eg_c | eg_d));
    check_eq("bus_we",      64'(bus_we),      64'(e_we));
    check_eq("bus_address", 64'(bus_address), 64'(e_addr));
    check_eq("bus_wdata",   64'(bus_wdata),   64'(e_wdata));
    check_eq("cpu_rvalid",  64'(cpu_rvalid),  64'(resp_c));
    check_eq("cpu_rdata",   64'(cpu_rdata),   resp_c ? 64'(rd) : 64'd0);
    check_eq("dma_rvalid",  64'(dma_rvalid),  64'(resp_d));
    check_eq("dma_rdata",   64'(dma_rdata),   resp_d ? 64'(rd) : 64'd0);

    if (r) begin
      resp_q.delete();
      m_starve = 0;
    end else begin
      if ((eg_c && !cwe) || (eg_d && !dwe)) resp_q.push_back('{cyc + RL, eg_d});
      if (dreq && !eg_d) m_starve = (m_starve < SL) ? m_starve + 1 : SL;
      else               m_starve = 0;
    end
    last_cgnt = eg_c;
    last_dgnt = eg_d;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  initial begin
    bit            c_req, c_we, d_req, d_we, r;
    logic [AW-1:0] c_a, d_a;
    logic [DW-1:0] c_w, d_w;

    // Reset values and a quiet bus after reset.
    step(1, 0, 0, '0, '0, 0, 0, '0, '0);
    step(1, 0, 0, '0, '0, 0, 0, '0, '0);
    idle(5);

    // Single CPU read, then a single DMA write.
    step(0, 1, 0, 32'h4, '0, 0, 0, '0, '0);
    idle(3);
    step(0, 0, 0, '0, '0, 1, 1, 32'h40C, 32'hF);
    idle(3);

    // Both reading continuously: DMA forced through every SL+1 cycles.
    for (int i = 0; i < 12; i++) step(0, 1, 0, 32'h100 + i, '0, 1, 0, 32'h200, '0);
    idle(3);

    // Interleaved owners in flight at once.
    step(0, 1, 0, 32'h404,   '0, 0, 0, '0, '0);
    step(0, 0, 0, '0,        '0, 1, 0, 32'h30000, '0);
    step(0, 1, 0, 32'h4100,  '0, 0, 0, '0, '0);
    idle(3);

    // Reset lands while a read is in flight.
    step(0, 1, 0, 32'h8, '0, 0, 0, '0, '0);
    step(1, 0, 0, '0, '0, 0, 0, '0, '0);
    idle(3);

    // Random traffic; a requester holds its request until granted.
    c_req = 0; d_req = 0; c_we = 0; d_we = 0;
    c_a = '0; d_a = '0; c_w = '0; d_w = '0;
    last_cgnt = 0; last_dgnt = 0;
    for (int i = 0; i < 600; i++) begin
      if (!c_req || last_cgnt) begin
        c_req = ($urandom_range(0, 3) != 0);
        c_we  = $urandom_range(0, 1) == 1;
        c_a   = $urandom;
        c_w   = $urandom;
      end
      if (!d_req || last_dgnt) begin
        d_req = ($urandom_range(0, 3) != 0);
        d_we  = $urandom_range(0, 1) == 1;
        d_a   = $urandom;
        d_w   = $urandom;
      end
      r = ($urandom_range(0, 63) == 0);
      step(r, c_req, c_we, c_a, c_w, d_req, d_we, d_a, d_w);
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
